// File: rtl/circuit_arbiter.sv
// circuit_arbiter
//   Shares a single fixed-latency `circuit` datapath between NREQ requesters.
//   Requesters are granted round-robin. The winner's operand goes out with a
//   one-cycle c_en pulse. After LAT cycles c_y is captured and returned,
//   tagged with the owner's index, on a valid/ready response channel.
//   Only one operation is in flight at a time.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   req_valid  per-requester request                       [NREQ]
//   req_data   operands, requester i at [i*DW +: DW]       [NREQ*DW]
//   req_ready  one-hot grant, combinational in IDLE only   [NREQ]
//   rsp_valid  result available (registered)
//   rsp_id     owner of the result (registered)            [IDW]
//   rsp_data   result, c_y sampled unmodified (registered) [DW]
//   rsp_ready  consumer accepts the result
//   c_en       enable pulse to the datapath (registered)
//   c_x        operand to the datapath (registered)        [DW]
//   c_y        result from the datapath                    [DW]
module circuit_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int DW   = 32,
    parameter int LAT  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [DW-1:0]      rsp_data,
    input  logic               rsp_ready,
    output logic               c_en,
    output logic [DW-1:0]      c_x,
    input  logic [DW-1:0]      c_y
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [DW-1:0]  cx_q, cx_d;
    logic           cen_q, cen_d;
    logic           rvalid_q, rvalid_d;
    logic [IDW-1:0] rid_q, rid_d;
    logic [DW-1:0]  rdata_q, rdata_d;

    logic           any_req;
    logic           found_hi;
    logic [IDW-1:0] sel_hi, sel_lo, sel, ptr_nxt;
    logic [DW-1:0]  sel_data;

    // Round-robin pick: the lowest valid index at or above ptr wins; if there
    // is none, wrap around to the lowest valid index overall.
    always_comb begin
        found_hi = 1'b0;
        any_req  = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (req_valid[j] && !found_hi && (j >= 32'(ptr_q))) begin
                found_hi = 1'b1;
                sel_hi   = IDW'(j);
            end
            if (req_valid[j] && !any_req) begin
                any_req = 1'b1;
                sel_lo  = IDW'(j);
            end
        end
        sel = found_hi ? sel_hi : sel_lo;
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            if (IDW'(j) == sel) begin
                sel_data = req_data[j*DW +: DW];
            end
        end
    end

    assign ptr_nxt = (sel == IDW'(NREQ - 1)) ? '0 : sel + 1'b1;

    // Gated by rst so that no grant is offered while reset is held, even
    // though the state register already reads IDLE.
    assign req_ready = (rst && (state_q == IDLE) && any_req) ? (NREQ'(1) << sel) : '0;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        cnt_d    = cnt_q;
        cx_d     = cx_q;
        cen_d    = 1'b0;
        rvalid_d = rvalid_q;
        rid_d    = rid_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    cx_d    = sel_data;
                    id_d    = sel;
                    ptr_d   = ptr_nxt;
                    cen_d   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d  = c_y;
                    rid_d    = id_q;
                    rvalid_d = 1'b1;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rvalid_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            id_q     <= '0;
            cnt_q    <= '0;
            cx_q     <= '0;
            cen_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rid_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            cnt_q    <= cnt_d;
            cx_q     <= cx_d;
            cen_q    <= cen_d;
            rvalid_q <= rvalid_d;
            rid_q    <= rid_d;
            rdata_q  <= rdata_d;
        end
    end

    assign c_en      = cen_q;
    assign c_x       = cx_q;
    assign rsp_valid = rvalid_q;
    assign rsp_id    = rid_q;
    assign rsp_data  = rdata_q;

endmodule

// File: tb/tb_circuit_arbiter.sv
// tb_circuit_arbiter
//   Two arbiters (LAT=1 and LAT=4) share one set of request/response inputs.
//   Each has a stand-in datapath that returns x^KEY exactly LAT cycles after
//   sampling c_en and returns a cycle-stamped junk value otherwise.
//   A transaction-level model predicts the outputs of both arbiters.
module tb_circuit_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int DW   = 32;
    localparam logic [DW-1:0] KEY = 32'h5A5A_0000;

    logic               clk;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic               rsp_ready;

    logic [NREQ-1:0]    req_ready [2];
    logic               rsp_valid [2];
    logic [IDW-1:0]     rsp_id    [2];
    logic [DW-1:0]      rsp_data  [2];
    logic               c_en      [2];
    logic [DW-1:0]      c_x       [2];
    logic [DW-1:0]      c_y       [2];

    logic [DW-1:0]      pipe0;
    logic [DW-1:0]      pipe1 [4];

    int n_checks = 0;
    int n_pass   = 0;

    // Model state, one entry per arbiter.
    bit            m_busy  [2];
    int            m_g     [2];
    int            m_owner [2];
    logic [DW-1:0] m_opnd  [2];
    logic [DW-1:0] m_cx    [2];
    int            m_ptr   [2];
    int            cyc = 0;

    int grants0[$], grants1[$], rsps0[$];

    assign c_y[0] = pipe0;
    assign c_y[1] = pipe1[3];

    circuit_arbiter #(.NREQ(NREQ), .IDW(IDW), .DW(DW), .LAT(1)) u_dut_lat1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_id(rsp_id[0]),
        .rsp_data(rsp_data[0]), .rsp_ready(rsp_ready), .c_en(c_en[0]),
        .c_x(c_x[0]), .c_y(c_y[0])
    );

    circuit_arbiter #(.NREQ(NREQ), .IDW(IDW), .DW(DW), .LAT(4)) u_dut_lat4 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_id(rsp_id[1]),
        .rsp_data(rsp_data[1]), .rsp_ready(rsp_ready), .c_en(c_en[1]),
        .c_x(c_x[1]), .c_y(c_y[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] opnd_of(input int i);
        return req_data[i*DW +: DW];
    endfunction

    function automatic int q_at(input int q[$], input int j);
        if (j < q.size()) return q[j];
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    // Model, handshake monitors and stand-in datapaths, advanced at each edge.
    initial begin
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0; m_g[i] = 0; m_owner[i] = 0;
            m_opnd[i] = '0; m_cx[i] = '0; m_ptr[i] = 0;
        end
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                for (int i = 0; i < 2; i++) begin
                    m_busy[i] = 1'b0; m_ptr[i] = 0; m_cx[i] = '0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    int p;
                    for (int r = 0; r < NREQ; r++) begin
                        if (req_valid[r] && req_ready[i][r]) begin
                            if (i == 0) grants0.push_back(r);
                            else        grants1.push_back(r);
                        end
                    end
                    if (i == 0 && rsp_valid[0] && rsp_ready) rsps0.push_back(int'(rsp_id[0]));
                    if (m_busy[i]) begin
                        if (cyc >= m_g[i] + 1 + lat_of(i) && rsp_ready) m_busy[i] = 1'b0;
                    end else begin
                        p = rr_pick(req_valid, m_ptr[i]);
                        if (p >= 0) begin
                            m_busy[i]  = 1'b1;
                            m_g[i]     = cyc + 1;
                            m_owner[i] = p;
                            m_opnd[i]  = opnd_of(p);
                            m_cx[i]    = opnd_of(p);
                            m_ptr[i]   = (p + 1) % NREQ;
                        end
                    end
                end
                pipe0    <= c_en[0] ? (c_x[0] ^ KEY) : {16'hDEAD, 16'(cyc)};
                pipe1[0] <= c_en[1] ? (c_x[1] ^ KEY) : {16'hBEEF, 16'(cyc)};
                pipe1[1] <= pipe1[0];
                pipe1[2] <= pipe1[1];
                pipe1[3] <= pipe1[2];
                cyc = cyc + 1;
            end
        end
    end

    // Per-cycle comparison of both arbiters against the model.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                logic [NREQ-1:0] e_rdy;
                logic            e_val;
                logic            e_en;
                int              p;
                string           pre;
                pre   = $sformatf("lat%0d", lat_of(i));
                e_rdy = '0;
                if (rst && !m_busy[i]) begin
                    p = rr_pick(req_valid, m_ptr[i]);
                    if (p >= 0) e_rdy[p] = 1'b1;
                end
                e_val = rst && m_busy[i] && (cyc >= m_g[i] + 1 + lat_of(i));
                e_en  = rst && m_busy[i] && (cyc == m_g[i]);
                chk({pre, "_req_ready"}, 64'(req_ready[i]), 64'(e_rdy));
                chk({pre, "_c_en"},      64'(c_en[i]),      64'(e_en));
                chk({pre, "_c_x"},       64'(c_x[i]),       64'(m_cx[i]));
                chk({pre, "_rsp_valid"}, 64'(rsp_valid[i]), 64'(e_val));
                if (!rst) begin
                    chk({pre, "_rst_rsp_id"},   64'(rsp_id[i]),   64'h0);
                    chk({pre, "_rst_rsp_data"}, 64'(rsp_data[i]), 64'h0);
                end else if (e_val) begin
                    chk({pre, "_rsp_id"},   64'(rsp_id[i]),   64'(m_owner[i]));
                    chk({pre, "_rsp_data"}, 64'(rsp_data[i]), 64'(m_opnd[i] ^ KEY));
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
    endtask

    task automatic drain(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        int k;
        int rr_exp [6];
        int ps_exp [3];
        rr_exp = '{0, 1, 2, 3, 0, 1};
        ps_exp = '{1, 3, 0};

        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        req_data  = {32'h3333_0003, 32'h0000_0007, 32'h2222_0002, 32'h1111_0001};
        #1;
        rst       = 1'b0;
        req_valid = '1;

        // Reset held with every requester valid.
        repeat (3) begin
            @(negedge clk);
            chk("rst_req_ready", 64'(req_ready[0]), 64'h0);
            chk("rst_rsp_valid", 64'(rsp_valid[0]), 64'h0);
            chk("rst_c_en",      64'(c_en[0]),      64'h0);
            chk("rst_c_x",       64'(c_x[0]),       64'h0);
        end
        @(posedge clk); #2;
        rst       = 1'b1;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;

        // Single request from requester 2 on the LAT=1 arbiter.
        @(negedge clk);
        chk("single_req_ready", 64'(req_ready[0]), 64'h4);
        @(posedge clk); #2;
        req_valid = '0;
        @(negedge clk);
        chk("single_c_en_hi", 64'(c_en[0]), 64'h1);
        chk("single_c_x",     64'(c_x[0]),  64'h7);
        @(negedge clk);
        chk("single_c_en_lo",   64'(c_en[0]),      64'h0);
        chk("single_rsp_early", 64'(rsp_valid[0]), 64'h0);
        @(negedge clk);
        chk("single_rsp_valid", 64'(rsp_valid[0]), 64'h1);
        chk("single_rsp_id",    64'(rsp_id[0]),    64'h2);
        chk("single_rsp_data",  64'(rsp_data[0]),  64'h5A5A_0007);
        drain(10);

        // Round-robin with all requesters continuously valid.
        do_reset();
        grants0.delete(); grants1.delete(); rsps0.delete();
        req_valid = '1;
        k = 0;
        while (rsps0.size() < 6 && k < 100) begin @(negedge clk); k++; end
        req_valid = '0;
        chk("rr_rsp_count", 64'(rsps0.size() >= 6), 64'h1);
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("rr_grant%0d", j), 64'(q_at(grants0, j)), 64'(rr_exp[j]));
            chk($sformatf("rr_rsp_id%0d", j), 64'(q_at(rsps0, j)), 64'(rr_exp[j]));
        end
        drain(15);

        // Pointer skip: after granting 1, only 0 and 3 remain valid.
        do_reset();
        grants0.delete(); grants1.delete(); rsps0.delete();
        req_valid = 4'b0010;
        k = 0;
        while (grants0.size() < 1 && k < 20) begin @(negedge clk); k++; end
        @(posedge clk); #2;
        req_valid = 4'b1001;
        k = 0;
        while (grants0.size() < 3 && k < 50) begin @(negedge clk); k++; end
        @(posedge clk); #2;
        req_valid = '0;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("skip_grant%0d", j), 64'(q_at(grants0, j)), 64'(ps_exp[j]));
        end
        drain(15);

        // Backpressure: pointer sits at 1, so requester 1 is served first.
        rsp_ready = 1'b0;
        req_valid = '1;
        k = 0;
        while (rsp_valid[0] !== 1'b1 && k < 20) begin @(negedge clk); k++; end
        chk("bp_rsp_valid", 64'(rsp_valid[0]), 64'h1);
        chk("bp_rsp_id",    64'(rsp_id[0]),    64'h1);
        chk("bp_rsp_data",  64'(rsp_data[0]),  64'h7878_0002);
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(rsp_valid[0]), 64'h1);
            chk("bp_hold_id",    64'(rsp_id[0]),    64'h1);
            chk("bp_hold_data",  64'(rsp_data[0]),  64'h7878_0002);
            chk("bp_hold_ready", 64'(req_ready[0]), 64'h0);
        end
        @(posedge clk); #2;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_exit_valid", 64'(rsp_valid[0]), 64'h1);
        @(negedge clk);
        chk("bp_after_valid", 64'(rsp_valid[0]), 64'h0);
        chk("bp_after_ready", 64'(req_ready[0]), 64'h4);
        @(negedge clk);
        chk("bp_next_c_en", 64'(c_en[0]), 64'h1);
        chk("bp_next_c_x",  64'(c_x[0]),  64'h7);
        req_valid = '0;
        drain(15);

        // Reset while the LAT=4 arbiter is waiting on the datapath.
        do_reset();
        req_valid = 4'b0100;
        @(posedge clk); #2;
        req_valid = '0;
        @(posedge clk); #2;
        @(negedge clk);
        chk("mr_wait_c_en",  64'(c_en[1]),      64'h0);
        chk("mr_wait_valid", 64'(rsp_valid[1]), 64'h0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        grants1.delete();
        repeat (8) begin
            @(negedge clk);
            chk("mr_no_rsp", 64'(rsp_valid[1]), 64'h0);
        end
        @(posedge clk); #2;
        req_valid = '1;
        @(negedge clk);
        chk("mr_first_ready", 64'(req_ready[1]), 64'h1);
        @(posedge clk); #2;
        chk("mr_first_grant", 64'(q_at(grants1, 0)), 64'h0);
        req_valid = '0;
        drain(15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/circuit_arbiter.md
Name: circuit_arbiter

Overview:
Shares one instance of the `circuit` datapath (en/x in, y out, fixed latency) between NREQ requesters. It grants requesters round-robin and issues one `en` pulse with the winner's operand. It then waits the datapath latency, captures `y`, and returns the result tagged with the requester ID over a valid/ready response channel. Only one operation is in flight at a time. The block sits between the client blocks and the `circuit` instance.

Parameters:
- NREQ, 4, number of requesters (2..16).
- IDW, 2, requester ID width; must equal clog2(NREQ).
- DW, 32, operand/result width; matches `circuit` x/y.
- LAT, 1, cycles from the posedge that samples c_en=1 to the posedge where c_y holds the result (1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  NREQ  per-requester operation request.
- req_data  in  NREQ*DW  operands; requester i occupies bits [i*DW +: DW].
- req_ready  out  NREQ  one-hot accept; a transfer occurs when req_valid[i] & req_ready[i].
- rsp_valid  out  1  result available.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_data  out  DW  result.
- rsp_ready  in  1  consumer accepts the result.
- c_en  out  1  enable to `circuit`.
- c_x  out  DW  operand to `circuit`.
- c_y  in  DW  result from `circuit`.

Behaviour:
- Reset (rst=0, async) forces all of the following. Released synchronously on the next posedge after rst=1.
  - state=IDLE.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0.
  - c_en=0, c_x=0.
  - Round-robin pointer ptr=0, latency counter=0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid is set, select the first asserted index scanning ptr, ptr+1, …, wrapping modulo NREQ.
  - req_ready is combinational in IDLE only: it is one-hot on the selected index, and 0 when no request is present.
  - On the transfer posedge:
    - latch c_x=req_data[sel] and id=sel;
    - set ptr=(sel+1) mod NREQ;
    - go to ISSUE.
  - No req_valid: stay in IDLE.
- ISSUE:
  - c_en=1 for exactly this one cycle, with c_x stable.
  - Next posedge: counter=LAT-1, go to WAIT.
- WAIT:
  - c_en=0; c_x holds its value.
  - While counter≠0, decrement each cycle.
  - At the posedge when counter==0: capture rsp_data=c_y, set rsp_id=id and rsp_valid=1, go to RESP.
  - Net latency from the req transfer posedge to rsp_valid rising is LAT+1 cycles.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_ready=1 at a posedge.
  - On that posedge: rsp_valid=0, go to IDLE.
  - No new request is accepted in the RESP-exit cycle; the earliest next grant is the cycle after.
- req_ready=0 in every state except IDLE. Requests may be withdrawn or changed while not granted, with no side effects.
- A requester deasserting req_valid in IDLE before the posedge simply produces no transfer. Selection is re-evaluated every cycle.
- ptr advances only on an actual transfer. A requester that is continuously valid is granted within NREQ operations.
- Widths: rsp_data is c_y sampled unmodified; no arithmetic is done in this block.
- Reset mid-operation: the in-flight result is discarded and no rsp_valid is produced. The `circuit` instance may still compute, but its output is ignored.
- All outputs are registered except req_ready (a function of state, ptr and req_valid).

Test Plan:
- Reset check: hold rst=0 for 3 cycles with all req_valid=1 → req_ready=0, rsp_valid=0, c_en=0, c_x=0 throughout.
- Single request, LAT=1:
  - Stimulus: req_valid=4'b0100, req_data[2]=32'h0000_0007.
  - c_en is high for exactly one cycle with c_x=7.
  - rsp_valid rises 2 cycles after the transfer, with rsp_id=2 and rsp_data equal to the c_y value present at the sampling edge.
- Round-robin fairness:
  - Stimulus: req_valid=4'b1111 held, rsp_ready=1 always.
  - Grant order is 0,1,2,3,0,1 and rsp_id follows the same sequence.
- Pointer skip:
  - Stimulus: after granting 1, only requesters 0 and 3 are valid.
  - Next grant is 3, then 0.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles in RESP.
  - rsp_valid, rsp_id and rsp_data stay stable; req_ready stays 0.
  - rsp_ready=1 → rsp_valid drops on the next posedge; the following grant occurs one cycle later.
- Mid-operation reset:
  - Stimulus: pulse rst=0 during WAIT with LAT=4.
  - No rsp_valid follows; the state returns to IDLE with ptr=0; the first grant afterwards is requester 0 when all requesters are valid.
